mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-requester arbiter in front of the single system memory/MMIO port (re/we/size/signed, mem_busy stall).
//  Port 0 = rv32i CPU; port 1 = secondary master (debug loader / DMA).
//  Registered grant, transaction lock until completion, round-robin or fixed priority, per-transaction watchdog.
// PARAMETERS
//  ARB_MODE      0   0 = round-robin, 1 = fixed priority (port 0 wins)
//  TIMEOUT       255 max owned cycles per transaction before abort; 0 disables watchdog
//  TO_W          8   watchdog counter width; must satisfy TIMEOUT < 2**TO_W
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  rqN_re       in   1   read request, N=0,1; held until completion
//  rqN_we       in   1   write request, N=0,1; re and we never both high
//  rqN_addr     in   32  byte address
//  rqN_wdata    in   32  write data
//  rqN_size     in   2   00 byte, 01 half, 10 word
//  rqN_signed   in   1   sign-extend load
//  rqN_busy     out  1   stall to requester N
//  rqN_rdata    out  32  read data, valid in the completion cycle
//  m_re         out  1   to memory: read strobe
//  m_we         out  1   to memory: write strobe
//  m_addr       out  32  to memory
//  m_wdata      out  32  to memory
//  m_size       out  2   to memory
//  m_signed     out  1   to memory
//  m_rdata      in   32  from memory
//  m_busy       in   1   from memory; a strobe completes in a cycle where it is high and m_busy is low
//  grant        out  2   one-hot current owner (00 = none)
//  timeout_err  out  1   sticky, set on watchdog abort; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, grant=00, rr_last=1 (port 0 favoured first), wd=0, timeout_err=0.
//   In IDLE, m_* outputs are 0.
//  States: IDLE, OWN0, OWN1.
//  IDLE:
//   - reqN = rqN_re|rqN_we.
//   - Neither req: stay in IDLE.
//   - One req: go to OWN of that port.
//   - Both, ARB_MODE=1: go to OWN0.
//   - Both, ARB_MODE=0: go to OWN of the port != rr_last.
//   - Arbitration latency: 1 cycle, so a request seen in IDLE is driven to memory the next cycle.
//  OWNx:
//   - m_* = rqx_* (combinational mux); grant = one-hot x.
//   - Completion: reqx & ~m_busy. On completion rr_last<=x, wd<=0, go to IDLE.
//   - Owner drops reqx without completing: go to IDLE, no rr_last update.
//   - Watchdog: wd increments every OWN cycle without completion. When wd==TIMEOUT (TIMEOUT!=0):
//     next state IDLE, timeout_err<=1, m_re/m_we forced 0 that cycle, rqx_busy=0 (requester is released,
//     rqx_rdata=0), rr_last<=x.
//  rqN_busy = reqN & ~(state==OWNN & ~m_busy); also forced low on watchdog abort of N.
//   A requester is stalled in every cycle it requests and does not complete.
//  rqN_rdata = m_rdata when granted N, else 0.
//  Minimum cost: 2 cycles per transaction (IDLE + OWN). Back-to-back requests from the same port re-arbitrate.
//  Fairness in round-robin mode: with both ports requesting continuously, grants alternate 0,1,0,1...
//  Requests arriving mid-transaction wait. The owner's address/data must stay stable while it is busy.
//  Asynchronous reset mid-transaction: all strobes drop immediately, grant=00.
// STRUCTURE
//  Shared package mem_bus_pkg: state encoding (IDLE/OWN0/OWN1), size codes (SZ_BYTE/HALF/WORD).
//  Single module; no sub-module. The watchdog is an inline counter.
//  Top level instantiates it between cpu and memory. Port 1 inputs are tied 0 when unused.
// TESTING
//  1 Reset, then rq0_re @0x100 with m_busy=0: grant=01 at cycle 2, m_re=1 at cycle 2,
//    rq0_busy high cycle 1, low cycle 2, rq0_rdata=m_rdata.
//  2 Both request from IDLE (mode 0), continuous: grant sequence 01,10,01,10; no port waits >1 transaction.
//  3 Same as 2, ARB_MODE=1: port 0 always wins; port 1 is served only when rq0 is idle in IDLE.
//  4 Owner write with m_busy held high 5 cycles: m_we stays high 6 cycles, rq1 request waits,
//    grant switches only after completion.
//  5 TIMEOUT=4, m_busy stuck high: abort after 4 OWN cycles; timeout_err=1 and stays 1;
//    rq busy released; the other port then granted.
//  6 Assert reset during OWN1 with m_busy high: m_we=0, grant=00 in the same cycle;
//    after release, normal arbitration resumes.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the system memory bus arbiter: ownership states and
// access-size codes as seen on the memory port.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of the single memory/MMIO port: registered grant,
// ownership held until completion, round-robin or fixed priority, per-transaction watchdog.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        rq0_re,
    input  logic        rq0_we,
    input  logic [31:0] rq0_addr,
    input  logic [31:0] rq0_wdata,
    input  logic [1:0]  rq0_size,
    input  logic        rq0_signed,
    output logic        rq0_busy,
    output logic [31:0] rq0_rdata,

    input  logic        rq1_re,
    input  logic        rq1_we,
    input  logic [31:0] rq1_addr,
    input  logic [31:0] rq1_wdata,
    input  logic [1:0]  rq1_size,
    input  logic        rq1_signed,
    output logic        rq1_busy,
    output logic [31:0] rq1_rdata,

    output logic        m_re,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    output logic        m_signed,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam bit          WD_EN    = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            timeout_err_q, timeout_err_d;

    logic req0, req1;
    logic own0, own1;
    logic owner_req;
    logic abort;

    assign req0 = rq0_re | rq0_we;
    assign req1 = rq1_re | rq1_we;
    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);

    assign owner_req = (own0 & req0) | (own1 & req1);
    // Abort wins over a same-cycle completion: the strobes are suppressed, so nothing completes.
    assign abort     = WD_EN & owner_req & (wd_q == WD_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_last_q     <= 1'b1;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (req0 && req1) begin
                    if (ARB_MODE == 1) state_d = ST_OWN0;
                    else               state_d = rr_last_q ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!owner_req) begin
                    // Owner withdrew without completing: no fairness credit.
                    state_d = ST_IDLE;
                    wd_d    = '0;
                end else if (abort) begin
                    state_d       = ST_IDLE;
                    wd_d          = '0;
                    rr_last_d     = own1;
                    timeout_err_d = 1'b1;
                end else if (!m_busy) begin
                    state_d   = ST_IDLE;
                    wd_d      = '0;
                    rr_last_d = own1;
                end else if (WD_EN) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wd_d    = '0;
            end
        endcase
    end

    always_comb begin
        m_re      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_size    = '0;
        m_signed  = 1'b0;
        rq0_rdata = '0;
        rq1_rdata = '0;
        if (own0) begin
            m_re      = rq0_re & ~abort;
            m_we      = rq0_we & ~abort;
            m_addr    = rq0_addr;
            m_wdata   = rq0_wdata;
            m_size    = rq0_size;
            m_signed  = rq0_signed;
            rq0_rdata = abort ? '0 : m_rdata;
        end else if (own1) begin
            m_re      = rq1_re & ~abort;
            m_we      = rq1_we & ~abort;
            m_addr    = rq1_addr;
            m_wdata   = rq1_wdata;
            m_size    = rq1_size;
            m_signed  = rq1_signed;
            rq1_rdata = abort ? '0 : m_rdata;
        end
    end

    // A requester stalls every cycle it asks and does not complete; an abort releases it.
    assign rq0_busy = req0 & ~(own0 & ~m_busy) & ~(own0 & abort);
    assign rq1_busy = req1 & ~(own1 & ~m_busy) & ~(own1 & abort);

    assign grant       = {own1, own0};
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three configurations (round-robin, fixed priority,
// short watchdog) share one stimulus stream and are checked against an ownership model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    typedef struct packed {
        logic        b0;
        logic        b1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sg;
        logic [1:0]  gnt;
        logic        terr;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq0_re = 0, rq0_we = 0, rq0_signed = 0;
    logic        rq1_re = 0, rq1_we = 0, rq1_signed = 0;
    logic [31:0] rq0_addr = 0, rq0_wdata = 0, rq1_addr = 0, rq1_wdata = 0;
    logic [1:0]  rq0_size = 0, rq1_size = 0;
    logic [31:0] m_rdata = 0;
    logic        m_busy = 0;

    logic        o_b0 [3];
    logic        o_b1 [3];
    logic [31:0] o_rd0 [3];
    logic [31:0] o_rd1 [3];
    logic        o_re [3];
    logic        o_we [3];
    logic [31:0] o_addr [3];
    logic [31:0] o_wd [3];
    logic [1:0]  o_sz [3];
    logic        o_sg [3];
    logic [1:0]  o_gnt [3];
    logic        o_te [3];

    int tests_run = 0;
    int tests_failed = 0;

    // Per-configuration parameters: dut0 RR/255, dut1 fixed/255, dut2 RR/4.
    int mode [3] = '{0, 1, 0};
    int tmo  [3] = '{255, 255, 4};

    // Model state: owner is -1 when nobody holds the bus.
    int owner [3];
    int last  [3];
    int wd    [3];
    bit terr  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bus_arbiter #(
            .ARB_MODE(g == 1 ? 1 : 0),
            .TIMEOUT (g == 2 ? 4 : 255),
            .TO_W    (8)
        ) u_dut (
            .clk(clk), .reset(reset),
            .rq0_re(rq0_re), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
            .rq0_size(rq0_size), .rq0_signed(rq0_signed), .rq0_busy(o_b0[g]), .rq0_rdata(o_rd0[g]),
            .rq1_re(rq1_re), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
            .rq1_size(rq1_size), .rq1_signed(rq1_signed), .rq1_busy(o_b1[g]), .rq1_rdata(o_rd1[g]),
            .m_re(o_re[g]), .m_we(o_we[g]), .m_addr(o_addr[g]), .m_wdata(o_wd[g]),
            .m_size(o_sz[g]), .m_signed(o_sg[g]), .m_rdata(m_rdata), .m_busy(m_busy),
            .grant(o_gnt[g]), .timeout_err(o_te[g])
        );
    end

    function automatic outs_t act_of(input int d);
        outs_t a;
        a.b0 = o_b0[d];   a.b1 = o_b1[d];
        a.rd0 = o_rd0[d]; a.rd1 = o_rd1[d];
        a.re = o_re[d];   a.we = o_we[d];
        a.addr = o_addr[d]; a.wdata = o_wd[d];
        a.size = o_sz[d]; a.sg = o_sg[d];
        a.gnt = o_gnt[d]; a.terr = o_te[d];
        return a;
    endfunction

    function automatic outs_t model_out(input int d);
        outs_t e;
        bit r0, r1, rx, ab;
        e = '0;
        r0 = rq0_re | rq0_we;
        r1 = rq1_re | rq1_we;
        e.terr = terr[d];
        if (owner[d] < 0) begin
            e.b0 = r0;
            e.b1 = r1;
        end else begin
            rx = (owner[d] == 0) ? r0 : r1;
            ab = rx && tmo[d] != 0 && wd[d] == tmo[d];
            if (owner[d] == 0) begin
                e.gnt = 2'b01;
                e.re = rq0_re && !ab; e.we = rq0_we && !ab;
                e.addr = rq0_addr; e.wdata = rq0_wdata; e.size = rq0_size; e.sg = rq0_signed;
                e.b0 = r0 && m_busy && !ab;
                e.b1 = r1;
                e.rd0 = ab ? 32'h0 : m_rdata;
            end else begin
                e.gnt = 2'b10;
                e.re = rq1_re && !ab; e.we = rq1_we && !ab;
                e.addr = rq1_addr; e.wdata = rq1_wdata; e.size = rq1_size; e.sg = rq1_signed;
                e.b1 = r1 && m_busy && !ab;
                e.b0 = r0;
                e.rd1 = ab ? 32'h0 : m_rdata;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            owner[d] = -1; last[d] = 1; wd[d] = 0; terr[d] = 0;
        end
    endtask

    task automatic model_update();
        bit r0, r1, rx;
        r0 = rq0_re | rq0_we;
        r1 = rq1_re | rq1_we;
        if (reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            if (owner[d] < 0) begin
                if (r0 && r1) owner[d] = (mode[d] == 1) ? 0 : 1 - last[d];
                else if (r0)  owner[d] = 0;
                else if (r1)  owner[d] = 1;
                wd[d] = 0;
            end else begin
                rx = (owner[d] == 0) ? r0 : r1;
                if (!rx) begin
                    owner[d] = -1; wd[d] = 0;
                end else if (tmo[d] != 0 && wd[d] == tmo[d]) begin
                    terr[d] = 1; last[d] = owner[d]; owner[d] = -1; wd[d] = 0;
                end else if (!m_busy) begin
                    last[d] = owner[d]; owner[d] = -1; wd[d] = 0;
                end else begin
                    wd[d]++;
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        rq0_re = 0; rq0_we = 0; rq1_re = 0; rq1_we = 0;
        rq0_addr = 0; rq0_wdata = 0; rq0_size = 0; rq0_signed = 0;
        rq1_addr = 0; rq1_wdata = 0; rq1_size = 0; rq1_signed = 0;
        m_busy = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        outs_t a;
        reset = 1;
        clear_inputs();
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            a = act_of(d);
            tests_run++;
            if ({a.gnt, a.re, a.we, a.terr, a.b0, a.b1} !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: got gnt=%b re=%b we=%b terr=%b, want all 0",
                         d, a.gnt, a.re, a.we, a.terr);
            end
        end
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_single_read();
        outs_t a;
        do_reset();
        rq0_re = 1; rq0_addr = 32'h100; rq0_size = SZ_WORD; m_busy = 0;
        m_rdata = $urandom;
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if ({a.gnt, a.re, a.b0} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_cyc1: got gnt=%b m_re=%b busy=%b, want 00/0/1", a.gnt, a.re, a.b0);
        end
        clk_step();
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if ({a.gnt, a.re, a.b0} !== 4'b0110 || a.addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL single_cyc2: got gnt=%b m_re=%b busy=%b addr=%h, want 01/1/0/00000100",
                     a.gnt, a.re, a.b0, a.addr);
        end
        tests_run++;
        if (a.rd0 !== m_rdata) begin
            tests_failed++;
            $display("FAIL single_rdata: got %h want %h", a.rd0, m_rdata);
        end
        clk_step();
        rq0_re = 0;
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if (a.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_idle: got gnt=%b want 00", a.gnt);
        end
        clk_step();
    endtask

    task automatic test_arbitration();
        outs_t a0, a1;
        logic [1:0] exp0, exp1;
        do_reset();
        rq0_re = 1; rq1_we = 1; m_busy = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            a0 = act_of(0);
            a1 = act_of(1);
            exp0 = 2'b00;
            exp1 = 2'b00;
            if (c % 2 == 0) begin
                exp0 = ((c / 2) % 2 == 1) ? 2'b01 : 2'b10;
                exp1 = 2'b01;
            end
            tests_run++;
            if (a0.gnt !== exp0) begin
                tests_failed++;
                $display("FAIL rr_grant cyc%0d: got %b want %b", c, a0.gnt, exp0);
            end
            tests_run++;
            if (a1.gnt !== exp1) begin
                tests_failed++;
                $display("FAIL fixed_grant cyc%0d: got %b want %b", c, a1.gnt, exp1);
            end
            clk_step();
        end
        rq0_re = 0;
        for (int c = 9; c <= 10; c++) begin
            @(negedge clk);
            a1 = act_of(1);
            exp1 = (c == 10) ? 2'b10 : 2'b00;
            tests_run++;
            if (a1.gnt !== exp1) begin
                tests_failed++;
                $display("FAIL fixed_port1 cyc%0d: got %b want %b", c, a1.gnt, exp1);
            end
            clk_step();
        end
        rq1_we = 0;
        clk_step();
    endtask

    task automatic test_long_write();
        outs_t a;
        logic [1:0] eg;
        int we_cycles;
        we_cycles = 0;
        do_reset();
        rq1_addr = 32'h200; rq1_wdata = $urandom; rq1_size = SZ_HALF;
        for (int c = 1; c <= 10; c++) begin
            rq1_we = (c <= 7);
            rq0_re = (c >= 2 && c <= 9);
            m_busy = (c >= 2 && c <= 6);
            @(negedge clk);
            a = act_of(0);
            if (a.we) we_cycles++;
            eg = (c >= 2 && c <= 7) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00;
            tests_run++;
            if (a.gnt !== eg) begin
                tests_failed++;
                $display("FAIL long_grant cyc%0d: got %b want %b", c, a.gnt, eg);
            end
            tests_run++;
            if (a.b0 !== (c >= 2 && c <= 8)) begin
                tests_failed++;
                $display("FAIL long_wait cyc%0d: got rq0_busy=%b want %b", c, a.b0, (c >= 2 && c <= 8));
            end
            clk_step();
        end
        tests_run++;
        if (we_cycles != 6) begin
            tests_failed++;
            $display("FAIL long_we_cycles: got %0d want 6", we_cycles);
        end
        clear_inputs();
        clk_step();
    endtask

    task automatic test_timeout();
        outs_t a;
        int ab_cyc;
        logic [1:0] eg;
        logic ere;
        ab_cyc = 2 + tmo[2];
        do_reset();
        m_rdata = $urandom | 32'h1;
        for (int c = 1; c <= 12; c++) begin
            rq0_re = (c <= ab_cyc);
            rq1_re = (c >= 2 && c <= ab_cyc + 3);
            m_busy = (c <= ab_cyc + 2);
            @(negedge clk);
            a = act_of(2);
            eg = (c >= 2 && c <= ab_cyc) ? 2'b01 :
                 (c == ab_cyc + 2 || c == ab_cyc + 3) ? 2'b10 : 2'b00;
            ere = (c >= 2 && c < ab_cyc) || c == ab_cyc + 2 || c == ab_cyc + 3;
            tests_run++;
            if (a.gnt !== eg || a.re !== ere) begin
                tests_failed++;
                $display("FAIL wd_grant cyc%0d: got gnt=%b m_re=%b want %b/%b", c, a.gnt, a.re, eg, ere);
            end
            tests_run++;
            if (a.terr !== (c > ab_cyc)) begin
                tests_failed++;
                $display("FAIL wd_err cyc%0d: got %b want %b", c, a.terr, (c > ab_cyc));
            end
            if (c == ab_cyc) begin
                tests_run++;
                if (a.b0 !== 1'b0 || a.rd0 !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL wd_release: got busy=%b rdata=%h want 0/0", a.b0, a.rd0);
                end
            end
            clk_step();
        end
        clear_inputs();
        repeat (3) clk_step();
        tests_run++;
        if (o_te[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_sticky: got %b want 1", o_te[2]);
        end
    endtask

    task automatic test_reset_mid();
        outs_t a;
        do_reset();
        rq1_we = 1; rq1_addr = 32'h300; m_busy = 1;
        @(negedge clk);
        clk_step();
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if (a.gnt !== 2'b10 || a.we !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_own: got gnt=%b m_we=%b want 10/1", a.gnt, a.we);
        end
        #2 reset = 1;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            a = act_of(d);
            tests_run++;
            if (a.gnt !== 2'b00 || a.we !== 1'b0 || a.terr !== 1'b0) begin
                tests_failed++;
                $display("FAIL rmid_drop dut%0d: got gnt=%b m_we=%b terr=%b want 00/0/0",
                         d, a.gnt, a.we, a.terr);
            end
        end
        @(posedge clk);
        #1 reset = 0;
        m_busy = 0;
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if (a.gnt !== 2'b00 || a.b1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_idle: got gnt=%b busy=%b want 00/1", a.gnt, a.b1);
        end
        clk_step();
        @(negedge clk);
        a = act_of(0);
        tests_run++;
        if (a.gnt !== 2'b10 || a.we !== 1'b1 || a.addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL rmid_resume: got gnt=%b m_we=%b addr=%h want 10/1/00000300",
                     a.gnt, a.we, a.addr);
        end
        clk_step();
        clear_inputs();
        clk_step();
    endtask

    task automatic test_random(input int cycles, input int busy_pct);
        outs_t a, e;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(3) == 0) begin
                if (rq0_re | rq0_we) begin
                    rq0_re = 0; rq0_we = 0;
                end else if ($urandom_range(1) == 0) rq0_re = 1;
                else rq0_we = 1;
            end
            if ($urandom_range(3) == 0) begin
                if (rq1_re | rq1_we) begin
                    rq1_re = 0; rq1_we = 0;
                end else if ($urandom_range(1) == 0) rq1_re = 1;
                else rq1_we = 1;
            end
            rq0_addr = $urandom; rq0_wdata = $urandom;
            rq1_addr = $urandom; rq1_wdata = $urandom;
            rq0_size = 2'($urandom_range(2)); rq1_size = 2'($urandom_range(2));
            rq0_signed = 1'($urandom_range(1)); rq1_signed = 1'($urandom_range(1));
            m_busy = ($urandom_range(99) < busy_pct);
            m_rdata = $urandom;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                a = act_of(d);
                e = model_out(d);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", d, c, a, e);
                end
            end
            clk_step();
        end
        clear_inputs();
        clk_step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_arbitration();
        test_long_write();
        test_timeout();
        test_reset_mid();
        test_random(400, 30);
        test_random(300, 85);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
